// File: rtl/reaction_controller.sv
// reaction_controller: 3-2-1 countdown, random hold-off, then timed reaction measurement.
// Revision: 1.0
`default_nettype none

module reaction_controller #(
  parameter int COUNT_MS   = 3000,
  parameter int RAND_MIN   = 2000,
  parameter int RAND_MAX   = 5000,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic [2:0]  fState,
  output logic [1:0]  digit,
  output logic        stim_led,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic [13:0] best_ms
);

  localparam int CD_W = (COUNT_MS < 2) ? 1 : $clog2(COUNT_MS + 1);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COUNT_MS);
  localparam logic [CD_W-1:0] CD_TH3  = CD_W'(2 * COUNT_MS / 3);
  localparam logic [CD_W-1:0] CD_TH2  = CD_W'(COUNT_MS / 3);
  localparam logic [12:0]     RND_LO  = 13'(RAND_MIN);
  localparam logic [12:0]     RND_HI  = 13'(RAND_MAX);
  localparam logic [13:0]     TMO     = 14'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    PREP    = 3'b001,
    TEST    = 3'b010,
    RESULT  = 3'b011,
    FAULT   = 3'b100,
    TIMEOUT = 3'b101
  } state_t;

  state_t          state;
  logic [CD_W-1:0] cd_cnt;
  logic [12:0]     wait_cnt;
  logic [12:0]     rnd;

  function automatic logic [1:0] digit_of(input logic [CD_W-1:0] cnt);
    logic [1:0] d;
    if (cnt > CD_TH3)
      d = 2'd3;
    else if (cnt > CD_TH2)
      d = 2'd2;
    else if (cnt != '0)
      d = 2'd1;
    else
      d = 2'd0;
    return d;
  endfunction

  // Free-running pseudo-random source; its value at the start press sets the hold-off.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rnd <= RND_LO;
    else if (rnd >= RND_HI)
      rnd <= RND_LO;
    else
      rnd <= rnd + 13'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      digit        <= 2'd0;
      stim_led     <= 1'b0;
      reaction_ms  <= 14'd0;
      result_valid <= 1'b0;
      best_ms      <= TMO;
      cd_cnt       <= '0;
      wait_cnt     <= 13'd0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_start) begin
            state       <= PREP;
            cd_cnt      <= CD_LOAD;
            wait_cnt    <= rnd;
            reaction_ms <= 14'd0;
            digit       <= digit_of(CD_LOAD);
          end
        end

        PREP: begin
          // A press here is a false start, even on the tick that would light the lamp.
          if (btn_react) begin
            state <= FAULT;
            digit <= 2'd0;
          end else if (tick_ms) begin
            if (cd_cnt != '0) begin
              cd_cnt <= cd_cnt - 1'b1;
              digit  <= digit_of(cd_cnt - 1'b1);
            end else if (wait_cnt > 13'd1) begin
              wait_cnt <= wait_cnt - 13'd1;
            end else begin
              wait_cnt    <= 13'd0;
              state       <= TEST;
              stim_led    <= 1'b1;
              reaction_ms <= 14'd0;
              digit       <= 2'd0;
            end
          end
        end

        TEST: begin
          // Reaction takes priority over a coincident tick so the shown time is pre-tick.
          if (btn_react) begin
            state        <= RESULT;
            stim_led     <= 1'b0;
            result_valid <= 1'b1;
            if (reaction_ms < best_ms)
              best_ms <= reaction_ms;
          end else if (tick_ms) begin
            if ({1'b0, reaction_ms} + 15'd1 >= {1'b0, TMO}) begin
              state       <= TIMEOUT;
              stim_led    <= 1'b0;
              reaction_ms <= TMO;
            end else begin
              reaction_ms <= reaction_ms + 14'd1;
            end
          end
        end

        RESULT, FAULT, TIMEOUT: begin
          if (btn_start)
            state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          digit    <= 2'd0;
          stim_led <= 1'b0;
        end
      endcase
    end
  end

  assign fState = state;

endmodule

`default_nettype wire

// File: tb/tb_reaction_controller.sv
// Directed self-checking bench for reaction_controller at default parameters.
`default_nettype none

module tb_reaction_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic [2:0]  fState;
  logic [1:0]  digit;
  logic        stim_led;
  logic [13:0] reaction_ms;
  logic        result_valid;
  logic [13:0] best_ms;

  int cmp = 0;
  int errs = 0;
  int rm = 0;

  reaction_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .btn_start    (btn_start),
    .btn_react    (btn_react),
    .fState       (fState),
    .digit        (digit),
    .stim_led     (stim_led),
    .reaction_ms  (reaction_ms),
    .result_valid (result_valid),
    .best_ms      (best_ms)
  );

  always #5 clk = ~clk;

  // Reference for the random source: 2000..5000 inclusive, one step per clk.
  always @(posedge clk) begin
    if (!rst_n)
      rm <= 2000;
    else
      rm <= (rm >= 5000) ? 2000 : rm + 1;
  end

  task automatic cyc(input logic t, input logic s, input logic r);
    tick_ms = t; btn_start = s; btn_react = r;
    @(posedge clk);
    #1;
    tick_ms = 1'b0; btn_start = 1'b0; btn_react = 1'b0;
  endtask

  task automatic start_and_run(input logic react_too, output int wait_len, output int ticks);
    wait_len = rm;
    cyc(1'b0, 1'b1, react_too);
    ticks = 0;
    while (fState != 3'b010 && ticks < 20000) begin
      cyc(1'b1, 1'b0, 1'b0);
      ticks++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    cmp++; if (fState !== 3'b000) begin errs++; $display("FAIL reset_state: got %0d expected 0", fState); end
    cmp++; if (digit !== 2'd0) begin errs++; $display("FAIL reset_digit: got %0d expected 0", digit); end
    cmp++; if (stim_led !== 1'b0) begin errs++; $display("FAIL reset_stim: got %0b expected 0", stim_led); end
    cmp++; if (reaction_ms !== 14'd0) begin errs++; $display("FAIL reset_reaction: got %0d expected 0", reaction_ms); end
    cmp++; if (result_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
    cmp++; if (best_ms !== 14'd9999) begin errs++; $display("FAIL reset_best: got %0d expected 9999", best_ms); end
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b000) begin errs++; $display("FAIL idle_react_ignored: got %0d expected 0", fState); end
  endtask

  task automatic test_normal;
    int n;
    int rv_cnt;
    logic [1:0] exp_d;
    n = 0;
    while (rm != 2500 && n < 4000) begin cyc(1'b0, 1'b0, 1'b0); n++; end
    cyc(1'b0, 1'b1, 1'b0);
    cmp++; if (fState !== 3'b001) begin errs++; $display("FAIL normal_prep: got %0d expected 1", fState); end
    cmp++; if (digit !== 2'd3) begin errs++; $display("FAIL normal_digit_start: got %0d expected 3", digit); end
    for (int i = 1; i <= 5500; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 999 || i == 1000 || i == 1999 || i == 2000 || i == 2999 || i == 3000) begin
        exp_d = (i < 1000) ? 2'd3 : (i < 2000) ? 2'd2 : (i < 3000) ? 2'd1 : 2'd0;
        cmp++; if (digit !== exp_d) begin errs++; $display("FAIL normal_digit_t%0d: got %0d expected %0d", i, digit, exp_d); end
      end
      if (i == 5499) begin
        cmp++; if (fState !== 3'b001 || stim_led !== 1'b0) begin errs++; $display("FAIL normal_pre_test: got state %0d stim %0b expected 1/0", fState, stim_led); end
      end
    end
    cmp++; if (fState !== 3'b010 || stim_led !== 1'b1) begin errs++; $display("FAIL normal_test_entry: got state %0d stim %0b expected 2/1", fState, stim_led); end
    rv_cnt = 0;
    for (int i = 0; i < 180; i++) begin cyc(1'b1, 1'b0, 1'b0); rv_cnt += int'(result_valid); end
    cmp++; if (reaction_ms !== 14'd180) begin errs++; $display("FAIL normal_running: got %0d expected 180", reaction_ms); end
    cyc(1'b0, 1'b0, 1'b1);
    rv_cnt += int'(result_valid);
    cmp++; if (fState !== 3'b011 || stim_led !== 1'b0) begin errs++; $display("FAIL normal_result: got state %0d stim %0b expected 3/0", fState, stim_led); end
    cmp++; if (reaction_ms !== 14'd180) begin errs++; $display("FAIL normal_reaction: got %0d expected 180", reaction_ms); end
    cmp++; if (best_ms !== 14'd180) begin errs++; $display("FAIL normal_best: got %0d expected 180", best_ms); end
    cyc(1'b0, 1'b0, 1'b1);
    rv_cnt += int'(result_valid);
    cmp++; if (rv_cnt != 1) begin errs++; $display("FAIL normal_valid_count: got %0d expected 1", rv_cnt); end
    cmp++; if (fState !== 3'b011 || reaction_ms !== 14'd180) begin errs++; $display("FAIL result_hold: got state %0d reaction %0d expected 3/180", fState, reaction_ms); end
    cyc(1'b1, 1'b1, 1'b0);
    cmp++; if (fState !== 3'b000 || reaction_ms !== 14'd180) begin errs++; $display("FAIL result_to_idle: got state %0d reaction %0d expected 0/180", fState, reaction_ms); end
  endtask

  task automatic test_false_start;
    logic seen;
    seen = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1200; i++) begin cyc(1'b1, 1'b0, 1'b0); seen |= stim_led; end
    cyc(1'b0, 1'b0, 1'b1);
    seen |= stim_led;
    cmp++; if (fState !== 3'b100) begin errs++; $display("FAIL false_state: got %0d expected 4", fState); end
    cmp++; if (seen !== 1'b0) begin errs++; $display("FAIL false_stim: got %0b expected 0", seen); end
    cmp++; if (reaction_ms !== 14'd0 || digit !== 2'd0) begin errs++; $display("FAIL false_outputs: got reaction %0d digit %0d expected 0/0", reaction_ms, digit); end
    cmp++; if (best_ms !== 14'd180) begin errs++; $display("FAIL false_best: got %0d expected 180", best_ms); end
    cyc(1'b0, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b100) begin errs++; $display("FAIL fault_hold: got %0d expected 4", fState); end
    cyc(1'b0, 1'b1, 1'b0);
    cmp++; if (fState !== 3'b000) begin errs++; $display("FAIL fault_to_idle: got %0d expected 0", fState); end
  endtask

  task automatic test_prep_edge;
    int w;
    w = rm;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000 + w - 1; i++) cyc(1'b1, 1'b0, 1'b0);
    cmp++; if (fState !== 3'b001) begin errs++; $display("FAIL edge_still_prep: got %0d expected 1", fState); end
    cyc(1'b1, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b100 || stim_led !== 1'b0 || reaction_ms !== 14'd0) begin errs++; $display("FAIL edge_false_start: got state %0d stim %0b reaction %0d expected 4/0/0", fState, stim_led, reaction_ms); end
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    int w, t;
    logic rv;
    rv = 1'b0;
    start_and_run(1'b0, w, t);
    cmp++; if (t != 3000 + w) begin errs++; $display("FAIL timeout_entry_ticks: got %0d expected %0d", t, 3000 + w); end
    for (int i = 0; i < 9998; i++) begin cyc(1'b1, 1'b0, 1'b0); rv |= result_valid; end
    cmp++; if (fState !== 3'b010 || reaction_ms !== 14'd9998) begin errs++; $display("FAIL timeout_pre: got state %0d reaction %0d expected 2/9998", fState, reaction_ms); end
    cyc(1'b1, 1'b0, 1'b0);
    rv |= result_valid;
    cmp++; if (fState !== 3'b101 || reaction_ms !== 14'd9999 || stim_led !== 1'b0) begin errs++; $display("FAIL timeout_state: got state %0d reaction %0d stim %0b expected 5/9999/0", fState, reaction_ms, stim_led); end
    cmp++; if (rv !== 1'b0 || best_ms !== 14'd180) begin errs++; $display("FAIL timeout_no_result: got valid %0b best %0d expected 0/180", rv, best_ms); end
    cyc(1'b1, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b101 || reaction_ms !== 14'd9999) begin errs++; $display("FAIL timeout_hold: got state %0d reaction %0d expected 5/9999", fState, reaction_ms); end
    cyc(1'b0, 1'b1, 1'b0);
    cmp++; if (fState !== 3'b000 || reaction_ms !== 14'd9999) begin errs++; $display("FAIL timeout_to_idle: got state %0d reaction %0d expected 0/9999", fState, reaction_ms); end
  endtask

  task automatic test_coincidence;
    int w, t;
    start_and_run(1'b0, w, t);
    cmp++; if (t != 3000 + w) begin errs++; $display("FAIL coinc_entry_ticks: got %0d expected %0d", t, 3000 + w); end
    for (int i = 1; i <= 250; i++) cyc(1'b1, (i == 100), 1'b0);
    cmp++; if (fState !== 3'b010 || reaction_ms !== 14'd250) begin errs++; $display("FAIL test_start_ignored: got state %0d reaction %0d expected 2/250", fState, reaction_ms); end
    cyc(1'b1, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b011 || reaction_ms !== 14'd250 || result_valid !== 1'b1) begin errs++; $display("FAIL coinc_result: got state %0d reaction %0d valid %0b expected 3/250/1", fState, reaction_ms, result_valid); end
    cmp++; if (best_ms !== 14'd180) begin errs++; $display("FAIL coinc_best: got %0d expected 180", best_ms); end
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int w, t;
    start_and_run(1'b0, w, t);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0);
    cmp++; if (reaction_ms !== 14'd50) begin errs++; $display("FAIL mid_running: got %0d expected 50", reaction_ms); end
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    cmp++; if (fState !== 3'b000 || digit !== 2'd0 || stim_led !== 1'b0) begin errs++; $display("FAIL mid_reset_ctl: got state %0d digit %0d stim %0b expected 0/0/0", fState, digit, stim_led); end
    cmp++; if (reaction_ms !== 14'd0 || result_valid !== 1'b0 || best_ms !== 14'd9999) begin errs++; $display("FAIL mid_reset_data: got reaction %0d valid %0b best %0d expected 0/0/9999", reaction_ms, result_valid, best_ms); end
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cmp++; if (fState !== 3'b001 || digit !== 2'd3 || reaction_ms !== 14'd0) begin errs++; $display("FAIL mid_fresh_start: got state %0d digit %0d reaction %0d expected 1/3/0", fState, digit, reaction_ms); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_best;
    int lens [4] = '{300, 200, 200, 400};
    int bests [4] = '{300, 200, 200, 200};
    int w, t;
    for (int k = 0; k < 4; k++) begin
      start_and_run((k == 0), w, t);
      cmp++; if (t != 3000 + w) begin errs++; $display("FAIL best%0d_entry_ticks: got %0d expected %0d", k, t, 3000 + w); end
      for (int i = 0; i < lens[k]; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      cmp++; if (result_valid !== 1'b1 || reaction_ms !== 14'(lens[k])) begin errs++; $display("FAIL best%0d_result: got valid %0b reaction %0d expected 1/%0d", k, result_valid, reaction_ms, lens[k]); end
      cmp++; if (best_ms !== 14'(bests[k])) begin errs++; $display("FAIL best%0d_value: got %0d expected %0d", k, best_ms, bests[k]); end
      cyc(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_prep_edge();
    test_timeout();
    test_coincidence();
    test_reset_mid();
    test_best();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

`default_nettype wire
